// File: rtl/spi_slave_frontend_if.sv
// ---------------------------------------------------------------------------
// spi_slave_frontend_if
//   Groups the SPI pins and the register-file bus of spi_slave_frontend.
//   slave  modport : the SPI slave front-end (drives MISO and the register bus).
//   master modport : the environment (SPI master pins plus register-file read data).
//   Signals
//     spi_clk, spi_mosi, spi_cs_n : SPI master -> slave pins (mode 0)
//     spi_miso                    : slave -> master serial data
//     reg_addr, reg_rd, reg_wr,
//     reg_wdata                   : register-file request side
//     reg_rdata                   : register-file read data, valid 1 clk after reg_rd
//     frame_done, frame_err       : per-frame status pulses
// ---------------------------------------------------------------------------
interface spi_slave_frontend_if #(
   parameter int ADDR_W = 4
);
   logic              spi_clk;
   logic              spi_mosi;
   logic              spi_miso;
   logic              spi_cs_n;
   logic [ADDR_W-1:0] reg_addr;
   logic              reg_rd;
   logic [7:0]        reg_rdata;
   logic              reg_wr;
   logic [7:0]        reg_wdata;
   logic              frame_done;
   logic              frame_err;

   modport slave (
      input  spi_clk, spi_mosi, spi_cs_n, reg_rdata,
      output spi_miso, reg_addr, reg_rd, reg_wr, reg_wdata, frame_done, frame_err
   );

   modport master (
      output spi_clk, spi_mosi, spi_cs_n, reg_rdata,
      input  spi_miso, reg_addr, reg_rd, reg_wr, reg_wdata, frame_done, frame_err
   );
endinterface

// File: rtl/spi_slave_frontend.sv
// ---------------------------------------------------------------------------
// spi_slave_frontend
//   SPI mode-0 slave front-end. The SPI pins are oversampled in clk_i, frames
//   of two bytes {cmd, data} are decoded and turned into single-cycle strobes
//   on a simple register-file bus. cmd[7]=1 is a write, cmd[7]=0 a read; the
//   low ADDR_W bits of cmd are the register address. Read data is shifted out
//   on MISO during the second byte of the same frame.
//   Ports
//     clk_i    : system clock, at least 8x the SPI clock
//     reset_i  : asynchronous reset, active low (0 = reset)
//     bus_io   : slave modport of spi_slave_frontend_if (SPI pins + register bus)
//   Parameters
//     ADDR_W      : register address width
//     SYNC_STAGES : synchronizer depth on spi_clk / spi_mosi / spi_cs_n (>= 2)
// ---------------------------------------------------------------------------
module spi_slave_frontend #(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   spi_slave_frontend_if.slave   bus_io
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CMD     = 2'd1,
      DATA    = 2'd2,
      WAIT_CS = 2'd3
   } state_t;

   state_t            state_q;
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic              sclk_prev_q;
   logic              cs_prev_q;
   logic [4:0]        bit_cnt_q;
   logic [7:0]        rx_sr_q;
   logic [7:0]        tx_sr_q;
   logic              is_wr_q;
   logic [1:0]        rd_pipe_q;
   logic [ADDR_W-1:0] reg_addr_q;
   logic              reg_rd_q;
   logic              reg_wr_q;
   logic [7:0]        reg_wdata_q;
   logic              frame_done_q;
   logic              frame_err_q;

   logic              sclk_s;
   logic              mosi_s;
   logic              cs_s;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              cs_rise;
   logic              cs_fall;
   logic [7:0]        rx_byte_d;
   logic [4:0]        bit_cnt_d;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   // Byte as it will look after the current sclk rise is shifted in.
   assign rx_byte_d = {rx_sr_q[6:0], mosi_s};
   assign bit_cnt_d = (bit_cnt_q == 5'd16) ? 5'd16 : bit_cnt_q + 5'd1;

   // MOSI goes through the same synchronizer depth as SCLK, so the value seen
   // together with a detected rise is the one the master set up for that rise.
   // cs_n resets to the inactive level so no false frame start follows reset.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus_io.spi_clk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_io.spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus_io.spi_cs_n};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         rx_sr_q      <= '0;
         tx_sr_q      <= '0;
         is_wr_q      <= 1'b0;
         rd_pipe_q    <= '0;
         reg_addr_q   <= '0;
         reg_rd_q     <= 1'b0;
         reg_wr_q     <= 1'b0;
         reg_wdata_q  <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         reg_rd_q     <= 1'b0;
         reg_wr_q     <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;

         // Read data arrives one clk after the reg_rd cycle; rd_pipe_q tracks
         // that so the capture lands on the cycle reg_rdata is valid.
         rd_pipe_q <= {rd_pipe_q[0], 1'b0};
         if (rd_pipe_q[1]) begin
            tx_sr_q <= bus_io.reg_rdata;
         end

         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q   <= CMD;
                  bit_cnt_q <= '0;
                  rx_sr_q   <= '0;
                  tx_sr_q   <= '0;
               end
            end

            CMD: begin
               if (cs_rise) begin
                  state_q     <= IDLE;
                  frame_err_q <= 1'b1;
                  rd_pipe_q   <= '0;
               end else if (sclk_rise) begin
                  rx_sr_q   <= rx_byte_d;
                  bit_cnt_q <= bit_cnt_d;
                  if (bit_cnt_q == 5'd7) begin
                     reg_addr_q <= rx_byte_d[ADDR_W-1:0];
                     is_wr_q    <= rx_byte_d[7];
                     state_q    <= DATA;
                     if (rx_byte_d[7]) begin
                        tx_sr_q <= 8'h00;
                     end else begin
                        reg_rd_q  <= 1'b1;
                        rd_pipe_q <= 2'b01;
                     end
                  end
               end
            end

            DATA: begin
               // A completing 16th rise takes priority over a simultaneous
               // cs_n rise; in that case there is no WAIT_CS to sit in.
               if (sclk_rise && (bit_cnt_q == 5'd15)) begin
                  bit_cnt_q    <= 5'd16;
                  rx_sr_q      <= rx_byte_d;
                  frame_done_q <= 1'b1;
                  if (is_wr_q) begin
                     reg_wr_q    <= 1'b1;
                     reg_wdata_q <= rx_byte_d;
                  end
                  state_q <= cs_rise ? IDLE : WAIT_CS;
               end else if (cs_rise) begin
                  state_q     <= IDLE;
                  frame_err_q <= 1'b1;
                  rd_pipe_q   <= '0;
               end else begin
                  if (sclk_rise) begin
                     rx_sr_q   <= rx_byte_d;
                     bit_cnt_q <= bit_cnt_d;
                  end
                  // The fall right after the 8th rise must not shift: bit 7 of
                  // the reply has to stay on MISO until the 9th rise.
                  if (sclk_fall && (bit_cnt_q > 5'd8)) begin
                     tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                  end
               end
            end

            WAIT_CS: begin
               if (cs_rise) begin
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  bit_cnt_q <= bit_cnt_d;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_io.spi_miso   = ((state_q == DATA) && !cs_s) ? tx_sr_q[7] : 1'b0;
   assign bus_io.reg_addr   = reg_addr_q;
   assign bus_io.reg_rd     = reg_rd_q;
   assign bus_io.reg_wr     = reg_wr_q;
   assign bus_io.reg_wdata  = reg_wdata_q;
   assign bus_io.frame_done = frame_done_q;
   assign bus_io.frame_err  = frame_err_q;

endmodule
